// File: rtl/truth_table_reader.sv
// Scans all 32 input vectors of a 5-input function and captures z into a table.
// Optional per-bit comparison against a latched expected table: TRUTH_TABLE_CHECK_EN.
module truth_table_reader #(
  parameter int unsigned SETTLE = 2
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        start,
  input  logic [31:0] expected,
  input  logic        z,
  output logic        y1,
  output logic        y0,
  output logic        x2,
  output logic        x1,
  output logic        x0,
  output logic        busy,
  output logic        done,
  output logic [31:0] table_out,
  output logic        pass,
  output logic [5:0]  mismatch_count,
  output logic [4:0]  first_fail,
  output logic        fail_valid,
  output logic [1:0]  dbg_state
);

  typedef enum logic [1:0] {S_IDLE, S_SETTLE, S_SAMPLE, S_DONE} state_t;

  localparam logic [3:0] SETTLE_LD   = 4'(SETTLE);
  localparam bit         SETTLE_ZERO = (SETTLE == 0);

  state_t      r_state;
  state_t      w_next;
  logic [4:0]  r_idx;
  logic [3:0]  r_cnt;
  logic [31:0] r_table;
  logic        w_accept;

  // Handshake: start is taken only in IDLE; busy covers SETTLE/SAMPLE; done pulses once per scan.
  assign w_accept = (r_state == S_IDLE) && start;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_state <= S_IDLE;
    else        r_state <= w_next;
  end

  always_comb begin
    w_next = r_state;
    case (r_state)
      S_IDLE:   if (start) w_next = SETTLE_ZERO ? S_SAMPLE : S_SETTLE;
      S_SETTLE: if (r_cnt <= 4'd1) w_next = S_SAMPLE;
      S_SAMPLE: begin
        if (r_idx == 5'd31) w_next = S_DONE;
        else                w_next = SETTLE_ZERO ? S_SAMPLE : S_SETTLE;
      end
      S_DONE:   w_next = S_IDLE;
      default:  w_next = S_IDLE;
    endcase
  end

  always_comb begin
    busy = 1'b0;
    done = 1'b0;
    case (r_state)
      S_SETTLE, S_SAMPLE: busy = 1'b1;
      S_DONE:             done = 1'b1;
      default:            ;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_idx   <= '0;
      r_cnt   <= '0;
      r_table <= '0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (start) begin
            r_idx   <= '0;
            r_cnt   <= SETTLE_LD;
            r_table <= '0;
          end
        end
        S_SETTLE: r_cnt <= r_cnt - 4'd1;
        S_SAMPLE: begin
          r_table[r_idx] <= z;
          if (r_idx != 5'd31) begin
            r_idx <= r_idx + 5'd1;
            r_cnt <= SETTLE_LD;
          end
        end
        S_DONE:  r_idx <= '0;
        default: ;
      endcase
    end
  end

  // Vector index is {x2,x1,x0,y1,y0}; it is 0 whenever the scanner is idle.
  assign {x2, x1, x0, y1, y0} = r_idx;
  assign table_out = r_table;
  assign dbg_state = r_state;

`ifdef TRUTH_TABLE_CHECK_EN
  logic [31:0] r_exp;
  logic [5:0]  r_mc;
  logic [4:0]  r_ff;
  logic        r_fv;
  logic        r_pass;
  logic        w_miss;

  assign w_miss = z ^ r_exp[r_idx];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_exp  <= '0;
      r_mc   <= '0;
      r_ff   <= '0;
      r_fv   <= 1'b0;
      r_pass <= 1'b0;
    end else if (w_accept) begin
      r_exp  <= expected;
      r_mc   <= '0;
      r_ff   <= '0;
      r_fv   <= 1'b0;
      r_pass <= 1'b0;
    end else if (r_state == S_SAMPLE) begin
      if (w_miss) begin
        r_mc <= r_mc + 6'd1;
        if (!r_fv) begin
          r_ff <= r_idx;
          r_fv <= 1'b1;
        end
      end
      // Last bit's verdict is folded in so pass is already valid during done.
      if (r_idx == 5'd31) r_pass <= (r_mc == 6'd0) && !w_miss;
    end
  end

  assign pass           = r_pass;
  assign mismatch_count = r_mc;
  assign first_fail     = r_ff;
  assign fail_valid     = r_fv;
`else
  logic w_unused_expected;
  assign w_unused_expected = ^expected;
  assign pass           = 1'b0;
  assign mismatch_count = '0;
  assign first_fail     = '0;
  assign fail_valid     = 1'b0;
`endif

endmodule

// File: tb/tb_truth_table_reader.sv
// Bench for truth_table_reader: two instances (SETTLE=2 and SETTLE=0), a programmable
// function-under-test model with optional 2-cycle lag, and a done-driven scoreboard.
module tb_truth_table_reader;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc++;

  int n_checks = 0;
  int n_fail   = 0;

  typedef struct packed {
    logic [31:0] tbl;
    logic        pass;
    logic [5:0]  mc;
    logic [4:0]  ff;
    logic        fv;
    logic [31:0] done_at;
  } exp_t;

  exp_t exp_q2[$];
  exp_t exp_q0[$];

  // ---------------- DUT with SETTLE=2 ----------------
  logic        start_2 = 1'b0;
  logic [31:0] expected_2 = '0;
  logic        z_2;
  logic        y1_2, y0_2, x2_2, x1_2, x0_2, busy_2, done_2, pass_2, fv_2;
  logic [31:0] table_2;
  logic [5:0]  mc_2;
  logic [4:0]  ff_2;
  logic [1:0]  dbg_2;
  logic [31:0] tt_2 = '0;
  int          lag_2 = 0;
  logic [4:0]  idx_2;
  logic [4:0]  p1_2 = '0;
  logic [4:0]  p2_2 = '0;

  truth_table_reader #(.SETTLE(2)) u_dut2 (
    .clk(clk), .rst_n(rst_n), .start(start_2), .expected(expected_2), .z(z_2),
    .y1(y1_2), .y0(y0_2), .x2(x2_2), .x1(x1_2), .x0(x0_2),
    .busy(busy_2), .done(done_2), .table_out(table_2), .pass(pass_2),
    .mismatch_count(mc_2), .first_fail(ff_2), .fail_valid(fv_2), .dbg_state(dbg_2)
  );

  assign idx_2 = {x2_2, x1_2, x0_2, y1_2, y0_2};
  always @(posedge clk) begin
    p1_2 <= idx_2;
    p2_2 <= p1_2;
  end
  assign z_2 = (lag_2 != 0) ? tt_2[p2_2] : tt_2[idx_2];

  // ---------------- DUT with SETTLE=0 ----------------
  logic        start_0 = 1'b0;
  logic [31:0] expected_0 = '0;
  logic        z_0;
  logic        y1_0, y0_0, x2_0, x1_0, x0_0, busy_0, done_0, pass_0, fv_0;
  logic [31:0] table_0;
  logic [5:0]  mc_0;
  logic [4:0]  ff_0;
  logic [1:0]  dbg_0;
  logic [31:0] tt_0 = '0;
  int          lag_0 = 0;
  logic [4:0]  idx_0;
  logic [4:0]  p1_0 = '0;
  logic [4:0]  p2_0 = '0;

  truth_table_reader #(.SETTLE(0)) u_dut0 (
    .clk(clk), .rst_n(rst_n), .start(start_0), .expected(expected_0), .z(z_0),
    .y1(y1_0), .y0(y0_0), .x2(x2_0), .x1(x1_0), .x0(x0_0),
    .busy(busy_0), .done(done_0), .table_out(table_0), .pass(pass_0),
    .mismatch_count(mc_0), .first_fail(ff_0), .fail_valid(fv_0), .dbg_state(dbg_0)
  );

  assign idx_0 = {x2_0, x1_0, x0_0, y1_0, y0_0};
  always @(posedge clk) begin
    p1_0 <= idx_0;
    p2_0 <= p1_0;
  end
  assign z_0 = (lag_0 != 0) ? tt_0[p2_0] : tt_0[idx_0];

  // ---------------- reference model ----------------
  // Truth table of z = single input bit b of the index {x2,x1,x0,y1,y0}.
  function automatic logic [31:0] rule_table(input int b);
    logic [31:0] r;
    for (int i = 0; i < 32; i++) r[i] = ((i >> b) & 1) != 0;
    return r;
  endfunction

  // Vector j is driven for cycles [j*(S+1), (j+1)*(S+1)) after accept; bit i is sampled at
  // offset (i+1)*(S+1) and a z lagging by L cycles reflects the vector of cycle offset
  // (i+1)*(S+1)-1-L. Before accept the idle stimulus equals vector 0.
  function automatic logic [31:0] model_table(input logic [31:0] tt, input int lag, input int settle);
    logic [31:0] r;
    for (int i = 0; i < 32; i++) begin
      int t;
      int v;
      t = (i + 1) * (settle + 1) - 1 - lag;
      v = (t < 0) ? 0 : t / (settle + 1);
      r[i] = tt[v];
    end
    return r;
  endfunction

  function automatic exp_t make_exp(input logic [31:0] tbl, input logic [31:0] expv, input int done_at);
    exp_t e;
    logic [31:0] d;
    d = tbl ^ expv;
    e.tbl = tbl;
    e.done_at = 32'(done_at);
`ifdef TRUTH_TABLE_CHECK_EN
    e.mc = 6'($countones(d));
    e.fv = (d != 0);
    e.pass = (d == 0);
    e.ff = '0;
    for (int i = 31; i >= 0; i--) if (d[i]) e.ff = 5'(i);
`else
    e.mc = '0;
    e.fv = 1'b0;
    e.pass = 1'b0;
    e.ff = '0;
`endif
    return e;
  endfunction

  // ---------------- scoreboard ----------------
  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  always @(negedge clk) begin
    exp_t e;
    if (rst_n === 1'b1 && done_2 === 1'b1) begin
      if (exp_q2.size() == 0) begin
        check("s2_unexpected_done", 64'd1, 64'd0);
      end else begin
        e = exp_q2.pop_front();
        check("s2_table", 64'(table_2), 64'(e.tbl));
        check("s2_pass", 64'(pass_2), 64'(e.pass));
        check("s2_mismatch_count", 64'(mc_2), 64'(e.mc));
        check("s2_first_fail", 64'(ff_2), 64'(e.ff));
        check("s2_fail_valid", 64'(fv_2), 64'(e.fv));
        check("s2_done_edge", 64'(cyc + 1), 64'(e.done_at));
        check("s2_busy_at_done", 64'(busy_2), 64'd0);
      end
    end
  end

  always @(negedge clk) begin
    exp_t e;
    if (rst_n === 1'b1 && done_0 === 1'b1) begin
      if (exp_q0.size() == 0) begin
        check("s0_unexpected_done", 64'd1, 64'd0);
      end else begin
        e = exp_q0.pop_front();
        check("s0_table", 64'(table_0), 64'(e.tbl));
        check("s0_pass", 64'(pass_0), 64'(e.pass));
        check("s0_mismatch_count", 64'(mc_0), 64'(e.mc));
        check("s0_first_fail", 64'(ff_0), 64'(e.ff));
        check("s0_fail_valid", 64'(fv_0), 64'(e.fv));
        check("s0_done_edge", 64'(cyc + 1), 64'(e.done_at));
        check("s0_busy_at_done", 64'(busy_0), 64'd0);
      end
    end
  end

  // ---------------- driver tasks ----------------
  function automatic int qsize(input bit s2);
    return s2 ? exp_q2.size() : exp_q0.size();
  endfunction

  task automatic drive_start(input bit s2, input logic st, input logic [31:0] ex);
    if (s2) begin start_2 = st; expected_2 = ex; end
    else    begin start_0 = st; expected_0 = ex; end
  endtask

  task automatic set_fut(input bit s2, input logic [31:0] tt, input int lag);
    if (s2) begin tt_2 = tt; lag_2 = lag; end
    else    begin tt_0 = tt; lag_0 = lag; end
  endtask

  task automatic push_exp(input bit s2, input exp_t e);
    if (s2) exp_q2.push_back(e);
    else    exp_q0.push_back(e);
  endtask

  task automatic wait_idle(input bit s2, input int budget);
    for (int k = 0; k < budget; k++) begin
      if (qsize(s2) == 0) break;
      @(negedge clk);
    end
    check(s2 ? "s2_done_timeout" : "s0_done_timeout", 64'(qsize(s2)), 64'd0);
    if (s2) exp_q2.delete();
    else    exp_q0.delete();
  endtask

  task automatic run_scan(input bit s2, input logic [31:0] tt, input int lag,
                          input logic [31:0] expv, input logic [31:0] tbl_exp, input bit poke);
    int settle;
    settle = s2 ? 2 : 0;
    set_fut(s2, tt, lag);
    repeat (4) @(negedge clk);
    drive_start(s2, 1'b1, expv);
    push_exp(s2, make_exp(tbl_exp, expv, cyc + 1 + 32 * (settle + 1) + 1));
    @(negedge clk);
    drive_start(s2, 1'b0, $urandom);
    check(s2 ? "s2_busy_after_accept" : "s0_busy_after_accept", 64'(s2 ? busy_2 : busy_0), 64'd1);
    if (poke) begin
      repeat ($urandom_range(3, 20)) @(negedge clk);
      drive_start(s2, 1'b1, $urandom);
      @(negedge clk);
      drive_start(s2, 1'b0, '0);
    end
    wait_idle(s2, 300);
    if (poke) repeat (110) @(negedge clk);
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, "_s2_outputs"},
          64'({y1_2, y0_2, x2_2, x1_2, x0_2, busy_2, done_2, table_2, pass_2, mc_2, ff_2, fv_2}), 64'd0);
    check({tag, "_s0_outputs"},
          64'({y1_0, y0_0, x2_0, x1_0, x0_0, busy_0, done_0, table_0, pass_0, mc_0, ff_0, fv_0}), 64'd0);
  endtask

  // ---------------- stimulus ----------------
  initial begin
    logic [31:0] tt;
    logic [31:0] ev;
    int t0;
    int t0b;
    exp_t e1;

    repeat (3) @(negedge clk);
    check_reset_outputs("reset");
    rst_n = 1'b1;
    @(negedge clk);
    check_reset_outputs("post_reset");

    // Fixed cases on the SETTLE=2 instance.
    run_scan(1'b1, 32'h0, 0, 32'h0000_0000, 32'h0000_0000, 1'b0);
    run_scan(1'b1, rule_table(2), 0, 32'hF0F0_F0F0, 32'hF0F0_F0F0, 1'b0);
    run_scan(1'b1, rule_table(1), 0, 32'hF0F0_F0F0, 32'hCCCC_CCCC, 1'b0);
    run_scan(1'b1, rule_table(4), 2, 32'hFFFF_0000, 32'hFFFF_0000, 1'b0);

    // Reset at vector 10, then a clean restart.
    tt = $urandom;
    set_fut(1'b1, tt, 0);
    repeat (4) @(negedge clk);
    drive_start(1'b1, 1'b1, tt);
    t0 = cyc + 1;
    push_exp(1'b1, make_exp(tt, tt, t0 + 97));
    @(negedge clk);
    drive_start(1'b1, 1'b0, '0);
    for (int k = 0; k < 200 && cyc < t0 + 30; k++) @(negedge clk);
    check("vector_before_reset", 64'(idx_2), 64'd10);
    rst_n = 1'b0;
    #1;
    check_reset_outputs("midscan_reset");
    exp_q2.delete();
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    repeat (120) @(negedge clk);
    run_scan(1'b1, tt, 0, tt ^ 32'h0000_0100, tt, 1'b0);

    // start pulsed while busy must be ignored.
    tt = $urandom;
    run_scan(1'b1, tt, 0, ~tt, tt, 1'b1);

    // start held high across two scans.
    tt = $urandom;
    ev = $urandom;
    set_fut(1'b1, tt, 0);
    repeat (4) @(negedge clk);
    drive_start(1'b1, 1'b1, ev);
    t0 = cyc + 1;
    e1 = make_exp(tt, ev, t0 + 97);
    push_exp(1'b1, e1);
    t0b = t0 + 97 + 1;
    push_exp(1'b1, make_exp(tt, ev, t0b + 97));
    for (int k = 0; k < 300 && cyc < t0b; k++) @(negedge clk);
    drive_start(1'b1, 1'b0, '0);
    wait_idle(1'b1, 300);

    // Random functions on the SETTLE=2 instance.
    for (int n = 0; n < 5; n++) begin
      tt = $urandom;
      case ($urandom_range(0, 2))
        0:       ev = tt;
        1:       ev = tt ^ (32'h1 << $urandom_range(0, 31));
        default: ev = $urandom;
      endcase
      run_scan(1'b1, tt, 0, ev, model_table(tt, 0, 2), 1'b0);
    end

    // SETTLE=0 instance: one vector per cycle.
    run_scan(1'b0, rule_table(0), 0, 32'hAAAA_AAAA, 32'hAAAA_AAAA, 1'b0);
    // A lagging function is sampled two vectors late without a settle window.
    run_scan(1'b0, rule_table(4), 2, 32'hFFFF_0000, model_table(rule_table(4), 2, 0), 1'b0);
    check("s0_lag_table_differs", 64'(table_0 != 32'hFFFF_0000), 64'd1);
    for (int n = 0; n < 4; n++) begin
      tt = $urandom;
      ev = (n[0]) ? tt : $urandom;
      run_scan(1'b0, tt, 0, ev, model_table(tt, 0, 0), 1'b0);
    end

    repeat (5) @(negedge clk);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
